note_sequencer: RTL and testbench

Pattern sequencer that sits directly upstream of the `synth` top, in the same 20.48 MHz `clk` domain. It stores a short loop of notes and drives the synth's `osc_count` and `trig` inputs. `trig` is held high and low long enough to pass the synth's two-stage synchronizer on the 78.125 Hz ADSR clock. Step timing comes from a free tick prescaler and a per-step tempo value.

---
 rtl/note_sequencer.sv | 131 +++++++++++++
 tb/tb_note_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: loops over a short pattern of notes and drives synth.osc_count / synth.trig.
// Ports: clk/rstn (sync active-low), wr_en/wr_addr/wr_data pattern write, run/length/tempo
//   playback control; osc_count, trig, step and step_strobe outputs, all registered.
// Optional build macro SEQ_REST_EN: a gate flag of 0 makes that step a rest (trig stays low).
module note_sequencer #(
  parameter int STEPS    = 16,
  parameter int TICK_DIV = 65536,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [12:0]   wr_data,
  input  logic          run,
  input  logic [AW-1:0] length,
  input  logic [7:0]    tempo,
  output logic [11:0]   osc_count,
  output logic          trig,
  output logic [AW-1:0] step,
  output logic          step_strobe
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

`ifdef SEQ_REST_EN
  localparam int MW = 13;
`else
  localparam int MW = 12;
  // The gate flag has no meaning in this build and is dropped at the write port.
  logic unused_gate;
  assign unused_gate = wr_data[12];
`endif

  typedef enum logic [1:0] {S_IDLE, S_GATE, S_LOW} state_t;

  logic [MW-1:0] mem [STEPS];
  state_t        state;
  logic [PW-1:0] presc;
  logic [8:0]    tick_cnt;   // ticks elapsed since the current step loaded
  logic [8:0]    step_len;   // T, 16..256
  logic [7:0]    gate_len;   // G = T>>1, 8..128

  logic          tick;
  logic [8:0]    tick_next;
  logic          gate_done;
  logic          step_done;
  logic          load_en;
  logic [AW-1:0] load_idx;
  logic [MW-1:0] load_ent;
  logic [7:0]    tempo_c;
  logic [8:0]    len_new;

  always_comb begin
    tick      = (presc == PS_LAST);
    tick_next = tick_cnt + 9'd1;
    gate_done = tick && (tick_next == {1'b0, gate_len});
    step_done = tick && (tick_next == step_len);
    load_en   = (state == S_IDLE) || ((state == S_LOW) && step_done);
    // Using >= rather than == also wraps when length was lowered below the current step.
    if ((state == S_IDLE) || (step >= length)) begin
      load_idx = '0;
    end else begin
      load_idx = step + AW'(1);
    end
    // A write to the entry being loaded this cycle is forwarded straight through.
    if (wr_en && (wr_addr == load_idx)) begin
      load_ent = wr_data[MW-1:0];
    end else begin
      load_ent = mem[load_idx];
    end
    // Minimum 16 ticks per step keeps both trig phases >= 8 ticks for the synth's synchronizer.
    tempo_c = (tempo < 8'd15) ? 8'd15 : tempo;
    len_new = {1'b0, tempo_c} + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STEPS; i++) begin
        mem[i] <= '0;
      end
      state       <= S_IDLE;
      presc       <= '0;
      tick_cnt    <= '0;
      step_len    <= '0;
      gate_len    <= '0;
      osc_count   <= '0;
      trig        <= 1'b0;
      step        <= '0;
      step_strobe <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data[MW-1:0];
      end
      step_strobe <= 1'b0;
      if (!run) begin
        // Stop wins over a load in the same cycle; osc_count is left as it was.
        state    <= S_IDLE;
        presc    <= '0;
        tick_cnt <= '0;
        trig     <= 1'b0;
        step     <= '0;
      end else if (load_en) begin
        state       <= S_GATE;
        presc       <= '0;
        tick_cnt    <= '0;
        step        <= load_idx;
        osc_count   <= load_ent[11:0];
        step_len    <= len_new;
        gate_len    <= len_new[8:1];
        step_strobe <= 1'b1;
`ifdef SEQ_REST_EN
        trig        <= load_ent[12];
`else
        trig        <= 1'b1;
`endif
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          tick_cnt <= tick_next;
        end
        if ((state == S_GATE) && gate_done) begin
          state <= S_LOW;
          trig  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;
  localparam int STEPS = 16;
  localparam int TD    = 16;
  localparam int AW    = 4;
`ifdef SEQ_REST_EN
  localparam bit REST = 1'b1;
`else
  localparam bit REST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [12:0]   wr_data = '0;
  logic          run = 1'b0;
  logic [AW-1:0] length = '0;
  logic [7:0]    tempo = '0;
  logic [11:0]   osc_count;
  logic          trig;
  logic [AW-1:0] step;
  logic          step_strobe;

  note_sequencer #(.STEPS(STEPS), .TICK_DIV(TD)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .run(run), .length(length), .tempo(tempo), .osc_count(osc_count), .trig(trig),
    .step(step), .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: step timing is tracked in plain clock cycles since the last load.
  logic [12:0] m_mem [STEPS];
  bit          m_play;
  int          m_el, m_per, m_gate, m_step, m_idx, m_t;
  logic [11:0] m_osc;
  bit          m_trig, m_strb, m_ld;
  logic [12:0] m_ent;

  // Observed history for the directed checks.
  int          cyc = 0;
  int          hi_cnt = 0;
  int          q_cyc[$];
  int          q_hi[$];
  int          q_step[$];
  logic [11:0] q_osc[$];

  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STEPS; i++) m_mem[i] = '0;
      m_play = 0; m_el = 0; m_per = 0; m_gate = 0; m_step = 0;
      m_osc = '0; m_trig = 0; m_strb = 0;
    end else begin
      m_ld = 0; m_idx = 0; m_strb = 0;
      if (!run) begin
        m_play = 0; m_trig = 0; m_step = 0;
      end else if (!m_play) begin
        m_ld = 1; m_idx = 0;
      end else begin
        m_el++;
        if (m_el == m_gate) m_trig = 0;
        if (m_el == m_per) begin
          m_ld = 1;
          m_idx = (m_step >= int'(length)) ? 0 : m_step + 1;
        end
      end
      if (m_ld) begin
        m_ent  = (wr_en && int'(wr_addr) == m_idx) ? wr_data : m_mem[m_idx];
        m_t    = ((int'(tempo) < 15) ? 15 : int'(tempo)) + 1;
        m_per  = m_t * TD;
        m_gate = (m_t / 2) * TD;
        m_osc  = m_ent[11:0];
        m_trig = REST ? m_ent[12] : 1'b1;
        m_step = m_idx; m_play = 1; m_el = 0; m_strb = 1;
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
    #1;
    cyc++;
    chk("osc_count", 32'(osc_count), 32'(m_osc));
    chk("trig", 32'(trig), 32'(m_trig));
    chk("step", 32'(step), 32'(m_step));
    chk("step_strobe", 32'(step_strobe), 32'(m_strb));
    if (step_strobe === 1'b1) begin
      q_cyc.push_back(cyc);
      q_hi.push_back(hi_cnt);
      q_step.push_back(int'(step));
      q_osc.push_back(osc_count);
      hi_cnt = (trig === 1'b1) ? 1 : 0;
    end else if (trig === 1'b1) begin
      hi_cnt++;
    end
  end

  task automatic clear_hist();
    q_cyc.delete(); q_hi.delete(); q_step.delete(); q_osc.delete();
  endtask

  task automatic wr(input int a, input logic [12:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns at the negedge where a strobe is visible (optionally for a given step).
  task automatic wait_strobe(input int maxc, input int want, input string nm);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < maxc) begin
      @(negedge clk);
      n++;
      hit = (step_strobe === 1'b1) && (want < 0 || int'(step) == want);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s timeout after %0d cycles", nm, maxc);
    end
  endtask

  initial begin
    int found;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_osc", 32'(osc_count), 32'h0);
    chk("reset_trig", 32'(trig), 32'h0);
    chk("reset_step", 32'(step), 32'h0);
    chk("reset_strobe", 32'(step_strobe), 32'h0);
    rstn = 1'b1;

    wr(0, {1'b1, 12'h100});
    wr(1, {1'b1, 12'h200});
    wr(2, {1'b1, 12'h300});
    wr(3, {1'b1, 12'h400});

    // Basic loop at tempo 15.
    @(negedge clk);
    tempo = 8'd15; length = AW'(3); clear_hist(); run = 1'b1;
    @(negedge clk);
    chk("start_strobe", 32'(step_strobe), 32'h1);
    chk("start_osc", 32'(osc_count), 32'h100);
    chk("start_trig", 32'(trig), 32'h1);
    repeat (5 * 256) @(negedge clk);
    chk("seq_osc0", 32'(q_osc[0]), 32'h100);
    chk("seq_osc1", 32'(q_osc[1]), 32'h200);
    chk("seq_osc2", 32'(q_osc[2]), 32'h300);
    chk("seq_osc3", 32'(q_osc[3]), 32'h400);
    chk("seq_osc4", 32'(q_osc[4]), 32'h100);
    chk("period_15", 32'(q_cyc[1] - q_cyc[0]), 32'd256);
    chk("period_15b", 32'(q_cyc[4] - q_cyc[3]), 32'd256);
    chk("trig_hi_15", 32'(q_hi[1]), 32'd128);

    // Tempo below the clamp.
    tempo = 8'd3; clear_hist();
    repeat (600) @(negedge clk);
    chk("period_clamped", 32'(q_cyc[1] - q_cyc[0]), 32'd256);
    chk("trig_hi_clamped", 32'(q_hi[1]), 32'd128);

    // Longer step.
    tempo = 8'd31; clear_hist();
    repeat (1200) @(negedge clk);
    chk("period_31", 32'(q_cyc[1] - q_cyc[0]), 32'd512);
    chk("trig_hi_31", 32'(q_hi[1]), 32'd256);

    // Stop mid-gate, then restart.
    tempo = 8'd15;
    wait_strobe(1200, -1, "stop_sync");
    repeat (40) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("stop_trig", 32'(trig), 32'h0);
    chk("stop_step", 32'(step), 32'h0);
    chk("stop_osc_held", 32'(osc_count), 32'(m_osc));
    repeat (5) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    chk("restart_strobe", 32'(step_strobe), 32'h1);
    chk("restart_step", 32'(step), 32'h0);
    chk("restart_osc", 32'(osc_count), 32'h100);

    // Shorten the loop while step 2 plays.
    wait_strobe(1500, 2, "len_sync");
    length = AW'(1);
    wait_strobe(600, -1, "len_wrap");
    chk("len_wrap_step", 32'(step), 32'h0);
    chk("len_wrap_osc", 32'(osc_count), 32'h100);
    length = AW'(3);

    // Write to index 1 on the very edge it is loaded.
    wait_strobe(1500, 0, "byp_sync");
    repeat (255) @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(1); wr_data = {1'b1, 12'hABC};
    @(negedge clk);
    wr_en = 1'b0;
    chk("bypass_strobe", 32'(step_strobe), 32'h1);
    chk("bypass_step", 32'(step), 32'h1);
    chk("bypass_osc", 32'(osc_count), 32'hABC);

    // Entry 1 with gate flag 0.
    wr(1, {1'b0, 12'h222});
    clear_hist();
    repeat (1300) @(negedge clk);
    found = 0;
    for (int i = 0; i + 1 < q_step.size(); i++) begin
      if (q_step[i] == 1) begin
        found++;
        chk("rest_osc", 32'(q_osc[i]), 32'h222);
        chk("rest_trig_hi", 32'(q_hi[i + 1]), REST ? 32'd0 : 32'd128);
      end
    end
    if (found == 0) begin
      checks++; errors++;
      $display("FAIL rest_step_seen got 0 expected >0");
    end

    // Randomised traffic against the model.
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      rstn  = ($urandom_range(0, 2999) != 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, STEPS - 1));
      wr_data = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 299) == 0) run = ~run;
      if ($urandom_range(0, 199) == 0) tempo = 8'($urandom_range(0, 40));
      if ($urandom_range(0, 199) == 0) length = AW'($urandom_range(0, STEPS - 1));
    end
    rstn = 1'b1; wr_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
